// File: rtl/step_resp_meas.sv
// Step-response meter: latches a baseline, then measures 12.5%->87.5% rise time and settling time.
// Define STEP_OVERSHOOT_EN to add peak-overshoot tracking; otherwise overshoot reads 0.
module step_resp_meas #(
  parameter int unsigned W           = 21,
  parameter int unsigned CW          = 16,
  parameter int unsigned TOL         = 16,
  parameter int unsigned SETTLE_HOLD = 4,
  parameter int unsigned MAX_SAMPLES = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic [W-1:0]  target,
  input  logic          sample_valid,
  input  logic [W-1:0]  sample,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic [CW-1:0] rise_cycles,
  output logic [CW-1:0] settle_cycles,
  output logic [W-1:0]  overshoot
);

  localparam int unsigned   SCW    = $clog2(MAX_SAMPLES + 1);
  localparam int unsigned   HCW    = $clog2(SETTLE_HOLD + 1);
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};
  localparam logic [W:0]    TolV   = (W+1)'(TOL);

  typedef enum logic [2:0] {StIdle, StArmed, StWait, StRise, StSettle, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   target_q, target_d, base_q, base_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [CW-1:0]  rise_cnt_q, rise_cnt_d, settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]  run_start_q, run_start_d, rise_q, rise_d, settle_q, settle_d;
  logic [HCW-1:0] run_q, run_d;
  logic           timed_out_q, timed_out_d, done_q, done_d;

  logic signed [W:0] delta_raw, d_raw, delta_n, d_n, lo, hi, err;
  logic [W:0]        err_abs;
  logic [W-1:0]      ov_now;
  logic              in_band, above, hi_cross, settled, ov_clr, ov_track, ov_unmeas;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CntMax) ? v : v + CW'(1);
  endfunction

  // Everything is compared in a frame where the step is positive.
  always_comb begin
    delta_raw = $signed({1'b0, target_q}) - $signed({1'b0, base_q});
    d_raw     = $signed({1'b0, sample}) - $signed({1'b0, base_q});
    delta_n   = delta_raw[W] ? -delta_raw : delta_raw;
    d_n       = delta_raw[W] ? -d_raw : d_raw;
    lo        = delta_n >>> 3;
    hi        = delta_n - lo;
    err       = $signed({1'b0, sample}) - $signed({1'b0, target_q});
    err_abs   = err[W] ? -err : err;
    in_band   = err_abs <= TolV;
    above     = d_n > delta_n;
    ov_now    = W'(d_n - delta_n);
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    base_d       = base_q;
    scnt_d       = scnt_q;
    rise_cnt_d   = rise_cnt_q;
    settle_cnt_d = settle_cnt_q;
    run_d        = run_q;
    run_start_d  = run_start_q;
    rise_d       = rise_q;
    settle_d     = settle_q;
    timed_out_d  = timed_out_q;
    done_d       = 1'b0;
    hi_cross     = 1'b0;
    settled      = 1'b0;
    ov_clr       = 1'b0;
    ov_track     = 1'b0;
    ov_unmeas    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d     = StArmed;
          target_d    = target;
          rise_d      = '0;
          settle_d    = '0;
          timed_out_d = 1'b0;
          ov_clr      = 1'b1;
        end
      end
      StArmed: begin
        if (sample_valid) begin
          base_d = sample;
          scnt_d = '0;
          if (sample == target_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait, StRise, StSettle: begin
        if (sample_valid) begin
          scnt_d = scnt_q + SCW'(1);
          if (state_q == StSettle) begin
            ov_track     = 1'b1;
            settle_cnt_d = sat_inc(settle_cnt_q);
            if (in_band) begin
              run_d = run_q + HCW'(1);
              if (run_q == '0) run_start_d = settle_cnt_d;
              if (run_d == HCW'(SETTLE_HOLD)) begin
                settled  = 1'b1;
                state_d  = StDone;
                done_d   = 1'b1;
                settle_d = run_start_d;
              end
            end else begin
              run_d = '0;
            end
          end else begin
            rise_cnt_d = (state_q == StRise) ? sat_inc(rise_cnt_q) : '0;
            if (d_n >= hi) begin
              hi_cross     = 1'b1;
              ov_track     = 1'b1;
              state_d      = StSettle;
              rise_d       = rise_cnt_d;
              settle_cnt_d = '0;
              run_d        = '0;
            end else if (state_q == StWait && d_n >= lo) begin
              state_d = StRise;
            end
          end
          // Settling on the last allowed sample wins over the timeout.
          if (!settled && scnt_d == SCW'(MAX_SAMPLES)) begin
            state_d     = StDone;
            done_d      = 1'b1;
            timed_out_d = 1'b1;
            settle_d    = CntMax;
            if (!hi_cross && state_q != StSettle) begin
              rise_d    = CntMax;
              ov_unmeas = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      target_q     <= '0;
      base_q       <= '0;
      scnt_q       <= '0;
      rise_cnt_q   <= '0;
      settle_cnt_q <= '0;
      run_q        <= '0;
      run_start_q  <= '0;
      rise_q       <= '0;
      settle_q     <= '0;
      timed_out_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      base_q       <= base_d;
      scnt_q       <= scnt_d;
      rise_cnt_q   <= rise_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      run_q        <= run_d;
      run_start_q  <= run_start_d;
      rise_q       <= rise_d;
      settle_q     <= settle_d;
      timed_out_q  <= timed_out_d;
      done_q       <= done_d;
    end
  end

`ifdef STEP_OVERSHOOT_EN
  logic [W-1:0] ov_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= '0;
    end else if (ov_clr) begin
      ov_q <= '0;
    end else if (ov_unmeas) begin
      ov_q <= '1;
    end else if (ov_track && above && ov_now > ov_q) begin
      ov_q <= ov_now;
    end
  end

  assign overshoot = ov_q;
`else
  logic unused_ov;
  assign unused_ov = ^{ov_clr, ov_track, ov_unmeas, above, ov_now};
  assign overshoot = '0;
`endif

  assign busy          = (state_q == StArmed) || (state_q == StWait) ||
                         (state_q == StRise) || (state_q == StSettle);
  assign done          = done_q;
  assign timed_out     = timed_out_q;
  assign rise_cycles   = rise_q;
  assign settle_cycles = settle_q;

endmodule

// File: tb/tb_step_resp_meas.sv
// Self-checking bench for step_resp_meas: directed scenarios plus random step traces scored
// against a whole-trace reference model.
module tb_step_resp_meas;

  localparam int W    = 21;
  localparam int CW   = 16;
  localparam int TOL  = 16;
  localparam int SH   = 4;
  localparam int MAXS = 64;
  localparam int VMAX = (1 << W) - 1;
  localparam int ONES = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  target = '0;
  logic [W-1:0]  sample = '0;
  logic          busy, done, timed_out;
  logic [CW-1:0] rise_cycles, settle_cycles;
  logic [W-1:0]  overshoot;

  int total = 0;
  int bad   = 0;

  step_resp_meas #(
    .W(W), .CW(CW), .TOL(TOL), .SETTLE_HOLD(SH), .MAX_SAMPLES(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .target(target),
    .sample_valid(sample_valid), .sample(sample), .busy(busy), .done(done),
    .timed_out(timed_out), .rise_cycles(rise_cycles), .settle_cycles(settle_cycles),
    .overshoot(overshoot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int done_idx;
    int to;
    int rise;
    int settle;
    int ov;
  } res_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > VMAX) return VMAX;
    return v;
  endfunction

  // Scans the valid-sample trace (index 0 = baseline) for the crossings and the first
  // window of SH in-band samples after the hi crossing.
  function automatic res_t model(input int tgt, input int s[$]);
    res_t r;
    int base, delta, dir, lo, hi, i_lo, i_hi, k_set, dn, ok;
    r = '{done_idx: 0, to: 0, rise: 0, settle: 0, ov: 0};
    base = s[0];
    delta = tgt - base;
    if (delta == 0) return r;
    dir = (delta < 0) ? -1 : 1;
    delta = delta * dir;
    lo = delta / 8;
    hi = delta - lo;
    i_lo = -1; i_hi = -1; k_set = -1;
    for (int n = 1; n < s.size(); n++) begin
      dn = (s[n] - base) * dir;
      if (i_lo < 0 && dn >= lo) i_lo = n;
      if (i_lo >= 0 && dn >= hi) begin
        i_hi = n;
        break;
      end
    end
    if (i_hi > 0) begin
      for (int n = i_hi + 1; n + SH - 1 < s.size(); n++) begin
        ok = 1;
        for (int m = n; m < n + SH; m++) if (iabs(s[m] - tgt) > TOL) ok = 0;
        if (ok == 1) begin
          k_set = n;
          break;
        end
      end
    end
    if (k_set > 0 && k_set + SH - 1 <= MAXS) begin
      r.done_idx = k_set + SH - 1;
      r.rise = i_hi - i_lo;
      r.settle = k_set - i_hi;
    end else begin
      r.done_idx = MAXS;
      r.to = 1;
      r.settle = ONES;
      r.rise = (i_hi > 0 && i_hi <= MAXS) ? i_hi - i_lo : ONES;
    end
    if (i_hi > 0 && i_hi <= r.done_idx) begin
      for (int n = i_hi; n <= r.done_idx; n++) begin
        dn = (s[n] - base) * dir - delta;
        if (dn > r.ov) r.ov = dn;
      end
    end else if (r.to == 1) begin
      r.ov = VMAX;
    end
    return r;
  endfunction

  task automatic do_arm(input int tgt, input bit collide);
    arm = 1'b1;
    target = W'(tgt);
    sample_valid = collide;
    sample = W'($urandom_range(VMAX, 0));
    tick();
    arm = 1'b0;
    sample_valid = 1'b0;
    check("arm_busy", 32'(busy), 1);
    check("arm_done", 32'(done), 0);
    check("arm_clr_to", 32'(timed_out), 0);
    check("arm_clr_rise", 32'(rise_cycles), 0);
    check("arm_clr_settle", 32'(settle_cycles), 0);
    check("arm_clr_ov", 32'(overshoot), 0);
  endtask

  task automatic run_trace(input string name, input int tgt, input int s[$], input bit gaps,
                           input bit busy_arm, input bit collide);
    res_t r;
    int g, exp_ov;
    r = model(tgt, s);
`ifdef STEP_OVERSHOOT_EN
    exp_ov = r.ov;
`else
    exp_ov = 0;
`endif
    do_arm(tgt, collide);
    for (int n = 0; n <= r.done_idx; n++) begin
      g = 0;
      if (gaps) g = (busy_arm && n == 3) ? 1 : int'($urandom_range(2, 0));
      for (int i = 0; i < g; i++) begin
        sample = W'($urandom_range(VMAX, 0));
        if (busy_arm && n == 3 && i == 0) begin
          arm = 1'b1;
          target = W'($urandom_range(VMAX, 0));
        end
        tick();
        arm = 1'b0;
        check({name, "_gap_busy"}, 32'(busy), 1);
        check({name, "_gap_done"}, 32'(done), 0);
      end
      sample = W'(s[n]);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check({name, "_done"}, 32'(done), (n == r.done_idx) ? 1 : 0);
      check({name, "_busy"}, 32'(busy), (n == r.done_idx) ? 0 : 1);
    end
    check({name, "_timed_out"}, 32'(timed_out), r.to);
    check({name, "_rise"}, 32'(rise_cycles), r.rise);
    check({name, "_settle"}, 32'(settle_cycles), r.settle);
    check({name, "_overshoot"}, 32'(overshoot), exp_ov);
    tick();
    check({name, "_done_pulse"}, 32'(done), 0);
    check({name, "_rise_hold"}, 32'(rise_cycles), r.rise);
  endtask

  task automatic gen_trace(output int tgt, output int s[$]);
    int base, mag, dir, steps, mode, k;
    s = {};
    base = int'($urandom_range(VMAX, 0));
    mag = int'($urandom_range(200000, 1000));
    dir = ($urandom_range(1, 0) == 1) ? 1 : -1;
    if (base + dir * mag > VMAX || base + dir * mag < 0) dir = -dir;
    tgt = base + dir * mag;
    s.push_back(base);
    k = int'($urandom_range(3, 0));
    repeat (k) s.push_back(base + dir * int'($urandom_range(8, 0)));
    mode = int'($urandom_range(3, 0));
    if (mode != 0) begin
      steps = int'($urandom_range(10, 2));
      for (int i = 1; i <= steps; i++) s.push_back(base + dir * mag * i / steps);
    end
    if (mode <= 1) begin
      while (s.size() < MAXS + 1) s.push_back(base + dir * mag / 2);
    end else begin
      k = int'($urandom_range(4, 0));
      repeat (k) s.push_back(clip(tgt + int'($urandom_range(mag / 2, 0)) - mag / 4));
      while (s.size() < MAXS + 1) s.push_back(clip(tgt + int'($urandom_range(40, 0)) - 20));
    end
  endtask

  initial begin
    int s[$];
    int tgt;

    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_to", 32'(timed_out), 0);
    check("rst_rise", 32'(rise_cycles), 0);
    check("rst_settle", 32'(settle_cycles), 0);
    check("rst_ov", 32'(overshoot), 0);
    #4 rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Rising step 0 -> 1000.
    s = {};
    for (int k = 0; k <= 10; k++) s.push_back(k * 100);
    while (s.size() < MAXS + 1) s.push_back(1000);
    run_trace("rise", 1000, s, 1'b0, 1'b0, 1'b0);

    // Falling step 1000 -> 0.
    s = {};
    for (int k = 10; k >= 0; k--) s.push_back(k * 100);
    while (s.size() < MAXS + 1) s.push_back(0);
    run_trace("fall", 0, s, 1'b0, 1'b0, 1'b0);

    // Overshoot to 1100 then back.
    s = {};
    for (int k = 0; k <= 11; k++) s.push_back(k * 100);
    while (s.size() < MAXS + 1) s.push_back(1000);
    run_trace("ovs", 1000, s, 1'b0, 1'b0, 1'b0);

    // Timeout with the sample stuck at baseline.
    s = {};
    while (s.size() < MAXS + 1) s.push_back(0);
    run_trace("tmo", 1000, s, 1'b0, 1'b0, 1'b0);

    // Run reset by an out-of-band sample, with valid gaps and an arm while busy.
    s = {};
    for (int k = 0; k <= 9; k++) s.push_back(k * 100);
    s.push_back(1000); s.push_back(1010); s.push_back(990); s.push_back(1030);
    s.push_back(1000); s.push_back(1005); s.push_back(995); s.push_back(1016);
    while (s.size() < MAXS + 1) s.push_back(1000);
    run_trace("runrst", 1000, s, 1'b1, 1'b1, 1'b1);

    // Reset mid-SETTLE.
    do_arm(1000, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      sample = W'(k * 100);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
    end
    check("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_rise", 32'(rise_cycles), 0);
    check("arst_settle", 32'(settle_cycles), 0);
    check("arst_ov", 32'(overshoot), 0);
    #2 rst_n = 1'b1;
    sample_valid = 1'b1;
    sample = W'(1000);
    tick();
    sample_valid = 1'b0;
    check("arst_idle", 32'(busy), 0);
    check("arst_idle_done", 32'(done), 0);

    // Degenerate step: target equals baseline.
    s = {};
    while (s.size() < MAXS + 1) s.push_back(500);
    run_trace("degen", 500, s, 1'b0, 1'b0, 1'b0);

    repeat (10) begin
      gen_trace(tgt, s);
      run_trace("rnd", tgt, s, bit'($urandom_range(1, 0)), 1'b0, bit'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
